// File: rtl/dma_controller.sv
// Single-channel DMA sequencer: CPU-programmed word moves over the shared bus, DR/DAR handshake.
// Optional macro DMA_BURST_LIMIT_EN caps each bus tenure at BURST_LEN beats.
module dma_controller #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic [DW-1:0] cfg_rdata,
  output logic          DR,
  input  logic          DAR,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          INT,
  output logic          MTM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic [AW-1:0]    ADDR_INC = AW'(4);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mtm;
  logic [DW-1:0]    r_hold;

  logic w_cfg_en;
  logic w_start;
  logic w_gap;
  logic w_burst_full;

  assign w_cfg_en = cfg_wr && (r_state == S_IDLE);
  assign w_start  = w_cfg_en && (cfg_addr == 2'd3) && cfg_wdata[0];

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    DR        = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    INT       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (r_cnt == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        DR = ~w_gap;
        if (!w_gap && DAR) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        DR       = 1'b1;
        bus_rd   = 1'b1;
        bus_addr = r_src;
        if (bus_ack) begin
          w_next = S_WR;
        end
      end
      S_WR: begin
        DR        = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = r_dst;
        bus_wdata = r_hold;
        if (bus_ack) begin
          w_next = S_STEP;
        end
      end
      S_STEP: begin
        DR = 1'b1;
        // Completion wins over a lost grant so the last word never re-requests the bus
        if (r_cnt <= CNT_ONE) begin
          w_next = S_DONE;
        end else if (!DAR || w_burst_full) begin
          w_next = S_REQ;
        end else begin
          w_next = S_RD;
        end
      end
      S_DONE: begin
        INT    = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Programmable registers and per-word address/count advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_cnt <= '0;
      r_mtm <= 1'b0;
    end else begin
      if (w_cfg_en) begin
        case (cfg_addr)
          2'd0:    r_src <= cfg_wdata[AW-1:0];
          2'd1:    r_dst <= cfg_wdata[AW-1:0];
          2'd2:    r_cnt <= cfg_wdata[CNT_W-1:0];
          default: r_mtm <= cfg_wdata[1];
        endcase
      end
      if (r_state == S_STEP) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_ONE;
        end
        r_dst <= r_dst + ADDR_INC;
        if (r_mtm) begin
          r_src <= r_src + ADDR_INC;
        end
      end
      if (r_state == S_DONE) begin
        r_mtm <= 1'b0;
      end
    end
  end

  // Read data holding register
  always_ff @(posedge clk) begin
    if ((r_state == S_RD) && bus_ack) begin
      r_hold <= bus_rdata;
    end
  end

`ifdef DMA_BURST_LIMIT_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  logic [BW-1:0] r_beats;
  logic          r_gap;

  // Beat counter restarts on every grant; a full tenure forces one DR-low cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats <= '0;
      r_gap   <= 1'b0;
    end else begin
      if ((r_state == S_REQ) && !r_gap && DAR) begin
        r_beats <= '0;
      end else if (r_state == S_STEP) begin
        r_beats <= r_beats + BW'(1);
      end
      r_gap <= (r_state == S_STEP) && (w_next == S_REQ) && w_burst_full;
    end
  end

  assign w_gap        = r_gap;
  assign w_burst_full = (r_beats == BW'(BURST_LEN - 1));
`else
  logic w_unused_burst;

  assign w_gap          = 1'b0;
  assign w_burst_full   = 1'b0;
  assign w_unused_burst = (BURST_LEN > 0);
`endif

  assign MTM       = r_mtm;
  assign cfg_rdata = {(r_state != S_IDLE), {(DW-1-CNT_W){1'b0}}, r_cnt};

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: expected writes queued at programming time, checked as the DUT writes.
module tb_dma_controller;

`ifdef DMA_BURST_LIMIT_EN
  localparam int TB_BURST     = 2;
  localparam int EXP_MTM_INT  = 14;
  localparam int EXP_IO_INT   = 16;
  localparam int EXP_MTM_GAPS = 1;
`else
  localparam int TB_BURST     = 8;
  localparam int EXP_MTM_INT  = 12;
  localparam int EXP_IO_INT   = 14;
  localparam int EXP_MTM_GAPS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        DR;
  logic        DAR;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        INT;
  logic        MTM;
  logic        ack_en;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int n_wr    = 0;
  int n_int   = 0;
  int int_cyc = -1;
  int drop_at = 0;
  bit dr_seen;
  bit strobe_seen;
  int gap_wr[$];
  logic [63:0] exp_q[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  assign bus_rdata = mem_rd(bus_addr);
  assign bus_ack   = ack_en;

  always #5 clk = ~clk;

  dma_controller #(
    .AW(32), .DW(32), .CNT_W(16), .BURST_LEN(TB_BURST)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .DR(DR), .DAR(DAR),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .INT(INT), .MTM(MTM)
  );

  // One clock: observe mid-cycle on the falling edge, return just after the rising edge
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    cyc++;
    n_vec++;
    if ((bus_rd && bus_wr) || (!bus_rd && !bus_wr && bus_addr !== 32'h0)) begin
      n_err++;
      $display("FAIL bus_idle_rules: rd=%b wr=%b addr=%h, required exclusive strobes and addr 0 when idle",
               bus_rd, bus_wr, bus_addr);
    end
    if (bus_rd || bus_wr) strobe_seen = 1'b1;
    if (DR) dr_seen = 1'b1;
    if (cfg_rdata[31] && !DR && !INT) gap_wr.push_back(n_wr);
    if (bus_wr && bus_ack) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", bus_addr, bus_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus_addr, bus_wdata} !== e) begin
          n_err++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   bus_addr, bus_wdata, e[63:32], e[31:0]);
        end
      end
      n_wr++;
      if (n_wr == drop_at) DAR = 1'b0;
    end
    if (INT) begin
      n_int++;
      int_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr    = 1'b0;
  endtask

  task automatic program_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt);
    cfg_write(2'd0, src);
    cfg_write(2'd1, dst);
    cfg_write(2'd2, cnt);
  endtask

  task automatic push_exp(input logic [31:0] src, input logic [31:0] dst, input int cnt, input bit mtm);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({dst + 32'(4 * i), mem_rd(mtm ? src + 32'(4 * i) : src)});
    end
  endtask

  task automatic start(input bit mode);
    logic [31:0] w;
    w    = 32'h0;
    w[0] = 1'b1;
    w[1] = mode;
    cfg_write(2'd3, w);
    cyc = 0;
  endtask

  task automatic clear_stats();
    n_wr = 0; n_int = 0; int_cyc = -1; drop_at = 0;
    dr_seen = 1'b0; strobe_seen = 1'b0;
    gap_wr.delete();
  endtask

  task automatic run_to_int(input int target, input int bound);
    int k;
    k = 0;
    while (n_int < target && k < bound) begin
      tick();
      k++;
    end
    n_vec++;
    if (n_int < target) begin
      n_err++;
      $display("FAIL int_timeout: %0d INT pulses after %0d cycles, required %0d", n_int, bound, target);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if ({DR, bus_rd, bus_wr, INT, MTM} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: DR,rd,wr,INT,MTM=%b, required 00000", {DR, bus_rd, bus_wr, INT, MTM});
    end
    n_vec++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0", bus_addr, bus_wdata);
    end
    n_vec++;
    if (cfg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: %h, required 00000000", cfg_rdata);
    end
  endtask

  task automatic test_mtm();
    DAR = 1'b0;
    program_xfer(32'h100, 32'h200, 32'd3);
    push_exp(32'h100, 32'h200, 3, 1'b1);
    clear_stats();
    start(1'b1);
    tick();
    n_vec++;
    if (MTM !== 1'b1 || DR !== 1'b1 || cfg_rdata !== 32'h8000_0003) begin
      n_err++;
      $display("FAIL mtm_req: MTM=%b DR=%b rdata=%h, required 1 1 80000003", MTM, DR, cfg_rdata);
    end
    DAR = 1'b1;
    run_to_int(1, 40);
    n_vec++;
    if (int_cyc != EXP_MTM_INT || n_int != 1) begin
      n_err++;
      $display("FAIL mtm_int: cycle %0d count %0d, required cycle %0d count 1", int_cyc, n_int, EXP_MTM_INT);
    end
    n_vec++;
    if (n_wr != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mtm_writes: %0d writes, %0d pending, required 3 and 0", n_wr, exp_q.size());
    end
    n_vec++;
    if (DR !== 1'b0 || MTM !== 1'b0 || cfg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL mtm_end: DR=%b MTM=%b rdata=%h, required 0 0 00000000", DR, MTM, cfg_rdata);
    end
    n_vec++;
    if (gap_wr.size() != EXP_MTM_GAPS) begin
      n_err++;
      $display("FAIL mtm_gaps: %0d DR-low cycles, required %0d", gap_wr.size(), EXP_MTM_GAPS);
    end
  endtask

  task automatic test_io();
    DAR = 1'b1;
    program_xfer(32'h40, 32'h300, 32'd4);
    push_exp(32'h40, 32'h300, 4, 1'b0);
    clear_stats();
    start(1'b0);
    n_vec++;
    if (MTM !== 1'b0 || DR !== 1'b1) begin
      n_err++;
      $display("FAIL io_req: MTM=%b DR=%b, required 0 1", MTM, DR);
    end
    run_to_int(1, 40);
    n_vec++;
    if (n_wr != 4 || exp_q.size() != 0 || n_int != 1 || int_cyc != EXP_IO_INT) begin
      n_err++;
      $display("FAIL io_xfer: writes=%0d pending=%0d ints=%0d int_cyc=%0d, required 4 0 1 %0d",
               n_wr, exp_q.size(), n_int, int_cyc, EXP_IO_INT);
    end
  endtask

  task automatic test_zero_count();
    cfg_write(2'd2, 32'd0);
    clear_stats();
    start(1'b1);
    tick();
    n_vec++;
    if (int_cyc != 1) begin
      n_err++;
      $display("FAIL zero_int: INT at cycle %0d, required 1", int_cyc);
    end
    repeat (4) tick();
    n_vec++;
    if (n_int != 1 || dr_seen || strobe_seen || MTM !== 1'b0) begin
      n_err++;
      $display("FAIL zero_quiet: ints=%0d dr=%b strobes=%b MTM=%b, required 1 0 0 0",
               n_int, dr_seen, strobe_seen, MTM);
    end
  endtask

  task automatic test_dar_drop();
    int k;
    DAR = 1'b1;
    program_xfer(32'h500, 32'h600, 32'd5);
    push_exp(32'h500, 32'h600, 5, 1'b1);
    clear_stats();
    drop_at = 2;
    start(1'b1);
    k = 0;
    while (DAR === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (DAR !== 1'b0) begin
      n_err++;
      $display("FAIL drop_timeout: %0d writes seen, required 2", n_wr);
    end
    repeat (7) tick();
    n_vec++;
    if (DR !== 1'b1 || bus_rd !== 1'b0 || bus_wr !== 1'b0 || n_wr != 2 || cfg_rdata !== 32'h8000_0003) begin
      n_err++;
      $display("FAIL drop_wait: DR=%b rd=%b wr=%b writes=%0d rdata=%h, required 1 0 0 2 80000003",
               DR, bus_rd, bus_wr, n_wr, cfg_rdata);
    end
    DAR = 1'b1;
    run_to_int(1, 40);
    n_vec++;
    if (n_wr != 5 || exp_q.size() != 0 || n_int != 1) begin
      n_err++;
      $display("FAIL drop_resume: writes=%0d pending=%0d ints=%0d, required 5 0 1", n_wr, exp_q.size(), n_int);
    end
  endtask

  task automatic test_busy_write_rst();
    int k;
    DAR = 1'b1;
    program_xfer(32'h1000, 32'h2000, 32'd4);
    push_exp(32'h1000, 32'h2000, 4, 1'b1);
    clear_stats();
    start(1'b1);
    cfg_write(2'd0, 32'hDEAD_0000);
    k = 0;
    while (!(n_wr == 1 && bus_rd === 1'b1) && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (n_wr != 1 || bus_rd !== 1'b1) begin
      n_err++;
      $display("FAIL rst_setup: writes=%0d rd=%b, required 1 1", n_wr, bus_rd);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({DR, bus_rd, bus_wr, INT, MTM} !== 5'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_outputs: DR,rd,wr,INT,MTM=%b addr=%h wdata=%h, required all 0",
               {DR, bus_rd, bus_wr, INT, MTM}, bus_addr, bus_wdata);
    end
    n_vec++;
    if (cfg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_rdata: %h, required 00000000", cfg_rdata);
    end
    exp_q.delete();
    repeat (5) tick();
    n_vec++;
    if (n_int != 0 || n_wr != 1) begin
      n_err++;
      $display("FAIL rst_discard: ints=%0d writes=%0d, required 0 1", n_int, n_wr);
    end
  endtask

  task automatic test_wrap();
    DAR = 1'b1;
    program_xfer(32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'd3);
    push_exp(32'hFFFF_FFFC, 32'hFFFF_FFF8, 3, 1'b1);
    clear_stats();
    start(1'b1);
    run_to_int(1, 40);
    n_vec++;
    if (n_wr != 3 || exp_q.size() != 0 || n_int != 1) begin
      n_err++;
      $display("FAIL wrap: writes=%0d pending=%0d ints=%0d, required 3 0 1", n_wr, exp_q.size(), n_int);
    end
  endtask

  task automatic test_back_to_back();
    DAR = 1'b1;
    clear_stats();
    program_xfer(32'h800, 32'h900, 32'd2);
    push_exp(32'h800, 32'h900, 2, 1'b1);
    start(1'b1);
    run_to_int(1, 40);
    program_xfer(32'h44, 32'hA00, 32'd2);
    push_exp(32'h44, 32'hA00, 2, 1'b0);
    start(1'b0);
    run_to_int(2, 40);
    n_vec++;
    if (n_wr != 4 || exp_q.size() != 0 || n_int != 2) begin
      n_err++;
      $display("FAIL back_to_back: writes=%0d pending=%0d ints=%0d, required 4 0 2", n_wr, exp_q.size(), n_int);
    end
  endtask

`ifdef DMA_BURST_LIMIT_EN
  task automatic test_burst();
    DAR = 1'b1;
    program_xfer(32'h100, 32'h400, 32'd5);
    push_exp(32'h100, 32'h400, 5, 1'b1);
    clear_stats();
    start(1'b1);
    run_to_int(1, 60);
    n_vec++;
    if (n_wr != 5 || exp_q.size() != 0 || n_int != 1 || DR !== 1'b0) begin
      n_err++;
      $display("FAIL burst_xfer: writes=%0d pending=%0d ints=%0d DR=%b, required 5 0 1 0",
               n_wr, exp_q.size(), n_int, DR);
    end
    n_vec++;
    if (gap_wr.size() != 2) begin
      n_err++;
      $display("FAIL burst_gaps: %0d DR-low cycles, required 2", gap_wr.size());
    end else begin
      n_vec++;
      if (gap_wr[0] != 2 || gap_wr[1] != 4) begin
        n_err++;
        $display("FAIL burst_gap_pos: after beats %0d,%0d, required 2,4", gap_wr[0], gap_wr[1]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cfg_wr    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 32'h0;
    DAR       = 1'b0;
    ack_en    = 1'b1;
    test_reset();
    test_mtm();
    test_io();
    test_zero_count();
    test_dar_drop();
    test_busy_write_rst();
    test_wrap();
    test_back_to_back();
`ifdef DMA_BURST_LIMIT_EN
    test_burst();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
